// File: rtl/scr_trigger_gen.sv
// scr_trigger_gen: alternating forward/negative SCR trigger pulses, one per mains half-cycle, with forbid/busy/done status
module scr_trigger_gen #(
  parameter int ARM_TIME    = 50000,
  parameter int PULSE_WIDTH = 500,
  parameter int HALF_PERIOD = 500000
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [15:0] i_cycles,
  output logic        o_pulse_forward,
  output logic        o_pulse_negative,
  output logic        o_forbid,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_cycle_cnt
);
  typedef enum logic [1:0] {IDLE, ARM, FWD, NEG} state_t;
  localparam logic [19:0] ARM_LAST = 20'(ARM_TIME - 1);
  localparam logic [19:0] HP_LAST  = 20'(HALF_PERIOD - 1);
  localparam logic [19:0] PW       = 20'(PULSE_WIDTH);
  state_t      state_q;
  logic [19:0] timer_q, timer_d;
  logic [15:0] target_q, cnt_q, cnt_d;
  logic        pfwd_q, pneg_q, forbid_q, busy_q, done_q;
  logic        pulse_d, half_end, run_end;
  // next timer value, saturating pair count and end-of-half/end-of-run decodes
  always_comb begin
    timer_d  = timer_q + 20'd1;
    cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    pulse_d  = timer_d < PW;
    half_end = timer_q == HP_LAST;
    run_end  = (target_q != 16'd0) && (cnt_d == target_q);
  end
  // run sequencer; every output is a register so nothing combinational reaches the SCR drivers
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      pfwd_q   <= 1'b0;
      pneg_q   <= 1'b0;
      forbid_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (i_start && !i_stop) begin
          state_q  <= ARM;
          target_q <= i_cycles;
          cnt_q    <= '0;
          timer_q  <= '0;
          forbid_q <= 1'b0;
          busy_q   <= 1'b1;
        end
      end else if (i_stop) begin
        state_q  <= IDLE;
        timer_q  <= '0;
        pfwd_q   <= 1'b0;
        pneg_q   <= 1'b0;
        forbid_q <= 1'b1;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ARM: begin
            if (timer_q == ARM_LAST) begin
              state_q <= FWD;
              timer_q <= '0;
              pfwd_q  <= 1'b1;
            end else begin
              timer_q <= timer_d;
            end
          end
          FWD: begin
            if (half_end) begin
              state_q <= NEG;
              timer_q <= '0;
              pfwd_q  <= 1'b0;
              pneg_q  <= 1'b1;
            end else begin
              timer_q <= timer_d;
              pfwd_q  <= pulse_d;
            end
          end
          default: begin
            if (half_end) begin
              cnt_q   <= cnt_d;
              timer_q <= '0;
              pneg_q  <= 1'b0;
              if (run_end) begin
                state_q  <= IDLE;
                done_q   <= 1'b1;
                forbid_q <= 1'b1;
                busy_q   <= 1'b0;
              end else begin
                state_q <= FWD;
                pfwd_q  <= 1'b1;
              end
            end else begin
              timer_q <= timer_d;
              pneg_q  <= pulse_d;
            end
          end
        endcase
      end
    end
  end
  assign o_pulse_forward  = pfwd_q;
  assign o_pulse_negative = pneg_q;
  assign o_forbid         = forbid_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_cycle_cnt      = cnt_q;
endmodule

// File: tb/tb_scr_trigger_gen.sv
// tb_scr_trigger_gen: directed scenario bench for scr_trigger_gen with ARM_TIME=4, PULSE_WIDTH=3, HALF_PERIOD=10
module tb_scr_trigger_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cycles = 16'd0;
  logic        pf, pn, forbid, busy, done;
  logic [15:0] cnt;
  int          tests = 0;
  int          fails = 0;

  scr_trigger_gen #(.ARM_TIME(4), .PULSE_WIDTH(3), .HALF_PERIOD(10)) dut (
    .i_clk_50m(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_stop(stop),
    .i_cycles(cycles),
    .o_pulse_forward(pf),
    .o_pulse_negative(pn),
    .o_forbid(forbid),
    .o_busy(busy),
    .o_done(done),
    .o_cycle_cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // starts a 2-pair run at E0 and checks every output through E50; optionally re-strobes start and changes i_cycles at edge restart
  task automatic run_nominal(input int restart, input string name);
    logic [20:0] exp, got;
    cycles = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if ({pf, pn, forbid, busy, done, cnt} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0}) begin
      fails++;
      $display("FAIL %s E0: got %h required %h", name, {pf, pn, forbid, busy, done, cnt}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0});
    end
    for (int e = 1; e <= 50; e++) begin
      if (e == restart) begin
        start = 1'b1;
        cycles = 16'd1;
      end
      if (e == restart + 1) start = 1'b0;
      tick();
      exp = {((e >= 4 && e < 7) || (e >= 24 && e < 27)),
             ((e >= 14 && e < 17) || (e >= 34 && e < 37)),
             e >= 44, e < 44, e == 44,
             (e < 24) ? 16'd0 : (e < 44) ? 16'd1 : 16'd2};
      got = {pf, pn, forbid, busy, done, cnt};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL %s E%0d {pf,pn,forbid,busy,done,cnt}: got %h required %h", name, e, got, exp);
      end
    end
    start = 1'b0;
    cycles = 16'd0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({pf, pn, forbid, busy, done, cnt} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      fails++;
      $display("FAIL reset_no_clock: got %h required %h", {pf, pn, forbid, busy, done, cnt}, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_two_cycles;
    run_nominal(-5, "two_cycles");
  endtask

  task automatic test_continuous;
    cycles = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 105; e++) begin
      tick();
      if (e == 24 || e == 64 || e == 104) begin
        tests++;
        if (cnt !== 16'((e - 4) / 20) || busy !== 1'b1 || done !== 1'b0) begin
          fails++;
          $display("FAIL continuous_cnt E%0d: got cnt=%0d busy=%b done=%b required cnt=%0d busy=1 done=0", e, cnt, busy, done, (e - 4) / 20);
        end
      end
    end
    tests++;
    if (pf !== 1'b1) begin
      fails++;
      $display("FAIL continuous_pf E105: got %b required 1", pf);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++;
    if ({pf, pn, forbid, busy, done, cnt} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5}) begin
      fails++;
      $display("FAIL continuous_abort E106: got %h required %h", {pf, pn, forbid, busy, done, cnt}, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5});
    end
    tick();
  endtask

  task automatic test_abort_fwd;
    int seen;
    cycles = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    tests++;
    if (pf !== 1'b1 || forbid !== 1'b0) begin
      fails++;
      $display("FAIL abort_fwd_pre E5: got pf=%b forbid=%b required pf=1 forbid=0", pf, forbid);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++;
    if ({pf, pn, forbid, busy, done} !== 5'b00100) begin
      fails++;
      $display("FAIL abort_fwd E6: got %b required 00100", {pf, pn, forbid, busy, done});
    end
    seen = 0;
    for (int e = 7; e <= 30; e++) begin
      tick();
      if (pn || pf || busy || done) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL abort_fwd_quiet: got %0d active cycles required 0", seen);
    end
    cycles = 16'd0;
  endtask

  task automatic test_restart_ignored;
    int seen;
    run_nominal(10, "restart_ignored");
    start = 1'b1;
    stop = 1'b1;
    tick();
    tests++;
    if (forbid !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL start_stop_idle: got forbid=%b busy=%b required forbid=1 busy=0", forbid, busy);
    end
    seen = 0;
    for (int e = 2; e <= 8; e++) begin
      tick();
      if (pf || busy || !forbid) seen++;
    end
    start = 1'b0;
    stop = 1'b0;
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL start_stop_idle_hold: got %0d active cycles required 0", seen);
    end
    tick();
  endtask

  task automatic test_reset_midrun;
    cycles = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 35; e++) tick();
    tests++;
    if (pn !== 1'b1 || cnt !== 16'd1) begin
      fails++;
      $display("FAIL reset_midrun_pre E35: got pn=%b cnt=%0d required pn=1 cnt=1", pn, cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({pf, pn, forbid, busy, done, cnt} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      fails++;
      $display("FAIL reset_midrun: got %h required %h", {pf, pn, forbid, busy, done, cnt}, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_nominal(-5, "after_reset");
  endtask

  initial begin
    test_reset();
    test_two_cycles();
    test_continuous();
    test_abort_fwd();
    test_restart_ignored();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
